// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes,
// blank pattern, scan FSM states and slot-length helper.
package seg_pkg;

  // All segments dark (active-low)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high segment patterns {g..a} for hex values 0..F
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Scan phase within one digit slot
  typedef enum logic {GUARD, SHOW} state_t;

  // Cycles per digit slot
  function automatic int unsigned slot_cycles(input int unsigned second,
                                              input int unsigned refresh_hz);
    return second / refresh_hz;
  endfunction

endpackage

// File: rtl/hex7_dec.sv
// Combinational hex to seven-segment decoder, active-low outputs {g..a}.
module hex7_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg_n
);

  // Invert the active-high table entry for active-low segment pins
  always_comb begin
    o_seg_n = ~SEG_CODES[i_code];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller.
// Each digit slot starts with GUARD cycles of all anodes off, then shows the
// digit for the rest of the slot. Outputs are registered one cycle behind the
// scan state. GUARD is expected to be at least 1.
// Optional macro SEG_SCAN_DP_EN adds the dp_mask input and dp_n output.
module seg_scan_ctrl #(
  parameter int unsigned SECOND     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned GUARD      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(DIGITS)-1:0] wr_addr,
  input  logic [3:0]                wr_data,
  input  logic [DIGITS-1:0]         blank_mask,
  output logic [6:0]                seg_n,
  output logic [DIGITS-1:0]         an_n,
  output logic                      frame_start
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [DIGITS-1:0]         dp_mask,
  output logic                      dp_n
`endif
);

  import seg_pkg::*;

  localparam int unsigned SLOT = seg_pkg::slot_cycles(SECOND, REFRESH_HZ);
  localparam int unsigned CW   = $clog2(SLOT);
  localparam int unsigned IW   = $clog2(DIGITS);

  // Digit storage and scan state
  logic [DIGITS-1:0][3:0] r_digit;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;

  // Registered outputs
  logic [DIGITS-1:0]      r_an_n;
  logic [6:0]             r_seg_n;
  logic                   r_frame_start;

  // Next-state and next-output signals
  state_t                 w_state_next;
  logic [CW-1:0]          w_cnt_next;
  logic [IW-1:0]          w_idx_next;
  logic [DIGITS-1:0]      w_sel;
  logic [DIGITS-1:0]      w_an_n_next;
  logic [6:0]             w_seg_n_next;
  logic                   w_frame_start_next;
  logic                   w_lit;
  logic [3:0]             w_cur_digit;
  logic [6:0]             w_dec_seg_n;

  // Register file; out-of-range addresses match no entry and are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (wr_addr == IW'(i)) begin
          r_digit[i] <= wr_data;
        end
      end
    end
  end

  // Scan state register: phase, slot counter, digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= seg_pkg::GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state logic: guard at slot start, show until the slot ends
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_idx_next   = r_idx;
    if (r_cnt == CW'(SLOT - 1)) begin
      w_cnt_next   = '0;
      w_state_next = seg_pkg::GUARD;
      w_idx_next   = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else if (r_cnt == CW'(GUARD - 1)) begin
      w_state_next = seg_pkg::SHOW;
    end
  end

  // One-hot anode select for the scanned digit
  generate
    for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == IW'(gi));
    end
  endgenerate

  assign w_cur_digit = r_digit[r_idx];
  assign w_lit       = (r_state == seg_pkg::SHOW) && !blank_mask[r_idx];

  hex7_dec u_dec (
    .i_code  (w_cur_digit),
    .o_seg_n (w_dec_seg_n)
  );

  // Output decode: dark unless showing a non-blanked digit
  always_comb begin
    w_an_n_next        = '1;
    w_seg_n_next       = SEG_OFF;
    w_frame_start_next = (r_state == seg_pkg::SHOW) && (r_cnt == CW'(GUARD)) &&
                         (r_idx == '0);
    if (w_lit) begin
      w_an_n_next  = ~w_sel;
      w_seg_n_next = w_dec_seg_n;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_n        <= '1;
      r_seg_n       <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_an_n        <= w_an_n_next;
      r_seg_n       <= w_seg_n_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  assign an_n        = r_an_n;
  assign seg_n       = r_seg_n;
  assign frame_start = r_frame_start;

`ifdef SEG_SCAN_DP_EN
  logic r_dp_n;

  // Decimal point follows the lit digit, registered alongside seg_n
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_n <= 1'b1;
    end else begin
      r_dp_n <= w_lit ? ~dp_mask[r_idx] : 1'b1;
    end
  end

  assign dp_n = r_dp_n;
`endif

endmodule
